// File: rtl/alu_requester.sv
// alu_requester: command FIFO feeding a one-outstanding ALU request FSM.
// Optional WAIT timeout: define ALU_REQ_TIMEOUT_EN.
module alu_requester #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_A,
  input  logic [31:0] cmd_B,
  input  logic [3:0]  cmd_mode,
  output logic        alu_valid,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [3:0]  alu_mode,
  input  logic        alu_ready,
  input  logic [63:0] alu_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic        res_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  mode;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  cmd_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          live_q;
  state_t        state_q;
  state_t        state_d;
  cmd_t          head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          bad_op;
  logic          alu_done;
  logic          tmo_hit;

  assign full      = count_q == DEPTH_C;
  assign empty     = count_q == '0;
  assign cmd_ready = live_q & ~full;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_q == IDLE) & ~empty;
  assign head      = mem_q[rd_ptr_q];
  assign bad_op    = head.mode > 4'd10;
  assign alu_done  = (state_q == WAIT) & alu_ready;
  assign alu_valid = state_q == ISSUE;
  assign res_valid = state_q == RESP;

  // Ready is held low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  // FIFO storage, written at the tail on every accepted command
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{a: cmd_A, b: cmd_B, mode: cmd_mode};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef ALU_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  logic [TW-1:0] tmo_q;

  // WAIT-cycle counter, restarted on the way into WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 tmo_q <= '0;
    else if (state_q == ISSUE)  tmo_q <= '0;
    else if (state_q == WAIT)   tmo_q <= tmo_q + TMO_ONE;
  end

  assign tmo_hit = (state_q == WAIT) & ~alu_ready & (tmo_q == TMO_LAST);
`else
  assign tmo_hit = 1'b0 & (TIMEOUT == 0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pop) state_d = bad_op ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (alu_done || tmo_hit) state_d = RESP;
      RESP:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU operands, loaded on a valid pop and held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_A    <= '0;
      alu_B    <= '0;
      alu_mode <= '0;
    end else if (pop && !bad_op) begin
      alu_A    <= head.a;
      alu_B    <= head.b;
      alu_mode <= head.mode;
    end
  end

  // Result register: ALU data, or zero with error for bad mode/timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      unique case (1'b1)
        pop && bad_op: begin
          res_data <= '0;
          res_err  <= 1'b1;
        end
        alu_done: begin
          res_data <= alu_data;
          res_err  <= 1'b0;
        end
        tmo_hit: begin
          res_data <= '0;
          res_err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_requester.sv
// tb_alu_requester: table vectors, directed corner sequences and a
// randomized run checked against a transaction-level model.
module tb_alu_requester;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  m;
  } cmd_t;

  typedef struct {
    logic [63:0] d;
    logic        e;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  m;
    int          dly;
    logic [63:0] alu_res;
    logic [63:0] exp_d;
    logic        exp_e;
    string       nm;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_A = '0;
  logic [31:0] cmd_B = '0;
  logic [3:0]  cmd_mode = '0;
  logic        alu_valid;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [3:0]  alu_mode;
  logic        alu_ready = 1'b0;
  logic [63:0] alu_data = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_data;
  logic        res_err;

  int n_chk = 0;
  int n_fail = 0;

  cmd_t send_q[$];
  cmd_t iss_q[$];
  res_t exp_q[$];
  bit          busy;
  int unsigned waitc;
  cmd_t        cur_cmd;
  logic [63:0] cur_res;
  int unsigned p_gap;
  int unsigned p_rdy;
  int unsigned max_dly;
  bit          alu_hold;
  int          n_acc;
  int          n_res;
  bit          last_rdy;

  alu_requester #(
    .FIFO_DEPTH(4),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_A(cmd_A),
    .cmd_B(cmd_B),
    .cmd_mode(cmd_mode),
    .alu_valid(alu_valid),
    .alu_A(alu_A),
    .alu_B(alu_B),
    .alu_mode(alu_mode),
    .alu_ready(alu_ready),
    .alu_data(alu_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_err(res_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [71:0] got, logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [63:0] alu_fn(cmd_t c);
    return {c.a ^ 32'h5A5A_0000, c.b} + {60'h0, c.m};
  endfunction

  function automatic res_t expect_of(cmd_t c);
    res_t r;
    if (c.m > 4'd10) begin
      r.d = '0;
      r.e = 1'b1;
    end else begin
      r.d = alu_fn(c);
      r.e = 1'b0;
    end
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_A = '0;
    cmd_B = '0;
    cmd_mode = '0;
    alu_ready = 1'b0;
    alu_data = '0;
    res_ready = 1'b0;
    send_q.delete();
    iss_q.delete();
    exp_q.delete();
    busy = 1'b0;
    waitc = 0;
    n_acc = 0;
    n_res = 0;
    #1;
    chk("rst_ctl", 72'({cmd_ready, alu_valid, res_valid, res_err, alu_mode}), 72'(0));
    chk("rst_data", 72'(res_data), 72'(0));
    chk("rst_ops", 72'({alu_A, alu_B}), 72'(0));
    repeat (2) @(negedge clk);
    chk("rst_ready", 72'(cmd_ready), 72'(0));
    rst_n = 1'b1;
  endtask

  // One cycle of bench-side ALU, command source and result sink
  task automatic agent_cycle();
    cmd_t c;
    res_t r;
    @(negedge clk);
    last_rdy = cmd_ready;
    alu_ready = 1'b0;
    alu_data = '0;
    if (alu_valid) begin
      chk("alu_single", 72'(busy), 72'(0));
      chk("alu_pending", 72'(iss_q.size() > 0), 72'(1));
      if (iss_q.size() > 0) begin
        c = iss_q.pop_front();
        chk("alu_req", 72'({alu_A, alu_B, alu_mode}), 72'({c.a, c.b, c.m}));
      end
      cur_cmd = '{alu_A, alu_B, alu_mode};
      cur_res = alu_fn(cur_cmd);
      busy = 1'b1;
      waitc = $urandom_range(max_dly);
    end else if (busy) begin
      chk("alu_hold", 72'({alu_A, alu_B, alu_mode}),
          72'({cur_cmd.a, cur_cmd.b, cur_cmd.m}));
      if (waitc > 0) begin
        waitc--;
      end else if (!alu_hold) begin
        alu_ready = 1'b1;
        alu_data = cur_res;
        busy = 1'b0;
      end
    end else if ($urandom_range(7) == 0) begin
      alu_ready = 1'b1;
      alu_data = {$urandom, $urandom};
    end
    if (send_q.size() > 0 && $urandom_range(99) >= p_gap) begin
      c = send_q[0];
      cmd_valid = 1'b1;
      cmd_A = c.a;
      cmd_B = c.b;
      cmd_mode = c.m;
    end else begin
      cmd_valid = 1'b0;
      cmd_A = $urandom;
      cmd_B = $urandom;
      cmd_mode = 4'($urandom);
    end
    if (cmd_valid && cmd_ready) begin
      c = send_q.pop_front();
      n_acc++;
      exp_q.push_back(expect_of(c));
      if (c.m <= 4'd10) iss_q.push_back(c);
    end
    res_ready = $urandom_range(99) < p_rdy;
    if (res_valid) begin
      chk("res_pending", 72'(exp_q.size() > 0), 72'(1));
      if (exp_q.size() > 0) begin
        r = exp_q[0];
        chk("res_data", 72'(res_data), 72'(r.d));
        chk("res_err", 72'(res_err), 72'(r.e));
        if (res_ready) begin
          r = exp_q.pop_front();
          n_res++;
        end
      end
    end
  endtask

  task automatic run_until_drained(string nm, int budget);
    int c;
    c = 0;
    while ((send_q.size() > 0 || exp_q.size() > 0) && c < budget) begin
      agent_cycle();
      c++;
    end
    chk({nm, "_drained"}, 72'(send_q.size() + exp_q.size() + iss_q.size()), 72'(0));
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    alu_ready = 1'b0;
  endtask

  task automatic run_one(vec_t v);
    cyc();
    chk({v.nm, "_cmd_ready"}, 72'(cmd_ready), 72'(1));
    cmd_valid = 1'b1;
    cmd_A = v.a;
    cmd_B = v.b;
    cmd_mode = v.m;
    cyc();
    cmd_valid = 1'b0;
    chk({v.nm, "_c1"}, 72'({alu_valid, res_valid}), 72'(0));
    cyc();
    if (v.exp_e) begin
      chk({v.nm, "_c2_err"}, 72'({alu_valid, res_valid}), 72'(2'b01));
    end else begin
      chk({v.nm, "_c2_issue"}, 72'({alu_valid, res_valid}), 72'(2'b10));
      chk({v.nm, "_req"}, 72'({alu_A, alu_B, alu_mode}), 72'({v.a, v.b, v.m}));
      for (int d = 0; d < v.dly; d++) begin
        cyc();
        chk({v.nm, "_wait"}, 72'({alu_valid, res_valid}), 72'(0));
      end
      cyc();
      chk({v.nm, "_ready_cyc"}, 72'({alu_valid, res_valid}), 72'(0));
      alu_ready = 1'b1;
      alu_data = v.alu_res;
      cyc();
      alu_ready = 1'b0;
      chk({v.nm, "_resp"}, 72'({alu_valid, res_valid}), 72'(2'b01));
    end
    chk({v.nm, "_data"}, 72'({res_data, res_err}), 72'({v.exp_d, v.exp_e}));
    alu_ready = 1'b1;
    alu_data = ~v.exp_d;
    res_ready = 1'b0;
    cyc();
    alu_ready = 1'b0;
    chk({v.nm, "_hold"}, 72'({res_valid, res_data, res_err}),
        72'({1'b1, v.exp_d, v.exp_e}));
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    chk({v.nm, "_done"}, 72'({alu_valid, res_valid}), 72'(0));
  endtask

  task automatic test_table();
    vec_t vt[7];
    vt[0] = '{32'd5, 32'd7, 4'd0, 0, 64'd12, 64'd12, 1'b0, "add5_7"};
    vt[1] = '{32'hFFFF_FFFF, 32'd1, 4'd0, 2, 64'h1_0000_0000,
              64'h1_0000_0000, 1'b0, "add_carry"};
    vt[2] = '{32'd3, 32'd4, 4'd9, 33, 64'd12, 64'd12, 1'b0, "mul_slow"};
    vt[3] = '{32'd1, 32'd2, 4'd13, 0, 64'd0, 64'd0, 1'b1, "mode13"};
    vt[4] = '{32'd9, 32'd9, 4'd10, 1, 64'hDEAD_BEEF_0123,
              64'hDEAD_BEEF_0123, 1'b0, "mode10"};
    vt[5] = '{32'd9, 32'd9, 4'd11, 0, 64'd0, 64'd0, 1'b1, "mode11"};
    vt[6] = '{32'd0, 32'd0, 4'd15, 0, 64'd0, 64'd0, 1'b1, "mode15"};
    do_reset();
    foreach (vt[i]) run_one(vt[i]);
  endtask

  task automatic test_backpressure();
    bit [5:0] seen;
    cmd_t c;
    do_reset();
    p_gap = 0;
    p_rdy = 0;
    max_dly = 0;
    alu_hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      c.a = 32'(i * 10 + 1);
      c.b = 32'(i + 100);
      c.m = 4'(i);
      send_q.push_back(c);
    end
    for (int k = 0; k < 6; k++) begin
      agent_cycle();
      seen[k] = last_rdy;
    end
    chk("bb_cmd_ready", 72'(seen), 72'(6'b011111));
    chk("bb_accepted", 72'(n_acc), 72'(5));
    alu_hold = 1'b0;
    p_rdy = 40;
    max_dly = 3;
    run_until_drained("bb", 400);
    chk("bb_results", 72'(n_res), 72'(6));
  endtask

  task automatic test_no_answer();
    int av;
    int first_rv;
    do_reset();
    cyc();
    cmd_valid = 1'b1;
    cmd_A = 32'd21;
    cmd_B = 32'd22;
    cmd_mode = 4'd0;
    cyc();
    cmd_valid = 1'b0;
    av = 0;
    first_rv = -1;
    for (int c = 2; c <= 120; c++) begin
      cyc();
      if (alu_valid) av++;
      if (res_valid && first_rv < 0) first_rv = c;
    end
    chk("tmo_alu_pulses", 72'(av), 72'(1));
`ifdef ALU_REQ_TIMEOUT_EN
    chk("tmo_resp_cycle", 72'(first_rv), 72'(67));
    chk("tmo_err", 72'({res_valid, res_data, res_err}), 72'({1'b1, 64'h0, 1'b1}));
    alu_ready = 1'b1;
    alu_data = '1;
    cyc();
    alu_ready = 1'b0;
    chk("tmo_stray_resp", 72'({res_valid, res_data, res_err}),
        72'({1'b1, 64'h0, 1'b1}));
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    alu_ready = 1'b1;
    alu_data = '1;
    cyc();
    alu_ready = 1'b0;
    cyc();
    chk("tmo_stray_idle", 72'({alu_valid, res_valid}), 72'(0));
`else
    chk("wait_no_resp", 72'(first_rv < 0), 72'(1));
    alu_ready = 1'b1;
    alu_data = 64'h0000_0042_0000_0077;
    cyc();
    alu_ready = 1'b0;
    chk("wait_late_ans", 72'({res_valid, res_data, res_err}),
        72'({1'b1, 64'h0000_0042_0000_0077, 1'b0}));
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
`endif
  endtask

  task automatic test_mid_reset();
    int act;
    do_reset();
    cyc();
    cmd_valid = 1'b1;
    cmd_A = 32'd1;
    cmd_B = 32'd2;
    cmd_mode = 4'd0;
    cyc();
    cmd_A = 32'd3;
    cyc();
    chk("mr_issue", 72'(alu_valid), 72'(1));
    cmd_A = 32'd5;
    cyc();
    cmd_valid = 1'b0;
    chk("mr_wait", 72'({alu_valid, res_valid, alu_A}), 72'({2'b00, 32'd1}));
    rst_n = 1'b0;
    #1;
    chk("mr_ctl", 72'({cmd_ready, alu_valid, res_valid, res_err, alu_mode}), 72'(0));
    chk("mr_ops", 72'({alu_A, alu_B}), 72'(0));
    chk("mr_data", 72'(res_data), 72'(0));
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("mr_ready", 72'(cmd_ready), 72'(1));
    alu_ready = 1'b1;
    alu_data = 64'h1234;
    act = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      alu_ready = 1'b0;
      if (alu_valid || res_valid) act++;
    end
    chk("mr_quiet", 72'(act), 72'(0));
  endtask

  task automatic test_random();
    cmd_t c;
    do_reset();
    p_gap = 30;
    p_rdy = 60;
    max_dly = 5;
    alu_hold = 1'b0;
    for (int i = 0; i < 300; i++) begin
      c.a = $urandom;
      c.b = $urandom;
      if ($urandom_range(3) == 0) c.m = 4'($urandom_range(15, 11));
      else c.m = 4'($urandom_range(10));
      send_q.push_back(c);
    end
    run_until_drained("rnd", 20000);
    chk("rnd_accepted", 72'(n_acc), 72'(300));
    chk("rnd_results", 72'(n_res), 72'(300));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_table();
    test_backpressure();
    test_no_answer();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_requester.md
ALU_REQUESTER -- requirements
Module: alu_requester

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the command FIFO depth in entries (power of two, at least 2).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, meaning the number of WAIT cycles allowed before abort (used only with the timeout macro).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have ports cmd_valid input 1, cmd_ready output 1, cmd_A input 32, cmd_B input 32 and cmd_mode input 4, forming the upstream command channel; a command transfers when cmd_valid and cmd_ready are both high.
REQ-006 The block SHALL have ports alu_valid output 1, alu_A output 32, alu_B output 32 and alu_mode output 4, forming the request to the ALU.
REQ-007 The block SHALL have ports alu_ready input 1 and alu_data input 64, forming the ALU completion pulse and its result.
REQ-008 The block SHALL have ports res_valid output 1, res_ready input 1, res_data output 64 and res_err output 1, forming the downstream result channel; a result transfers when res_valid and res_ready are both high.

Function
REQ-009 The command FIFO SHALL be FIFO_DEPTH entries, each holding {A, B, mode}, with cmd_ready equal to not-full.
- Push when full is impossible.
- Simultaneous push and pop SHALL keep the count unchanged.
- Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-010 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, all registered.
REQ-011 IDLE with the FIFO non-empty SHALL pop one entry at the clock edge and move as follows:
- mode 0-10: go to ISSUE, loading alu_A, alu_B and alu_mode from the entry.
- mode 11-15: go to RESP with res_data = 0 and res_err = 1, without driving alu_valid.
REQ-012 alu_valid SHALL be high exactly during ISSUE, which lasts one cycle, and ISSUE SHALL always go to WAIT.
REQ-013 alu_A, alu_B and alu_mode SHALL hold stable from ISSUE until the next pop.
REQ-014 In WAIT, a sampled alu_ready = 1 SHALL capture alu_data into res_data, clear res_err and move to RESP.
REQ-015 alu_ready SHALL be ignored in every state other than WAIT.
REQ-016 In RESP, res_valid SHALL be 1, and res_data and res_err SHALL hold until res_ready = 1, after which the FSM SHALL return to IDLE with res_valid = 0.
REQ-017 Latency SHALL be as follows for a command accepted at the edge ending cycle 0 into an empty, idle block:
- alu_valid high in cycle 2.
- For a one-cycle ALU op (ready in cycle 3), res_valid high in cycle 4.
REQ-018 The block SHALL have at most one ALU operation outstanding, and results SHALL be returned in command order.
REQ-019 Commands SHALL be accepted in any FSM state while the FIFO is not full.

Reset
REQ-020 Asserting rst_n low at any time, including mid-operation, SHALL immediately:
- empty the FIFO;
- force the FSM to IDLE;
- set cmd_ready = 0 while in reset;
- set alu_valid, res_valid and res_err to 0;
- set alu_A, alu_B, alu_mode and res_data to 0;
- clear the timeout counter.
REQ-021 After reset release, cmd_ready SHALL be 1 from the first clock edge, and no in-flight ALU result SHALL be replayed.

Configuration
REQ-022 With ALU_REQ_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
- On reaching TIMEOUT without alu_ready, the FSM SHALL go to RESP with res_data = 0 and res_err = 1.
- A later stray alu_ready SHALL be ignored unless the FSM is again in WAIT.
REQ-023 Without ALU_REQ_TIMEOUT_EN, no counter SHALL exist and WAIT SHALL last until alu_ready.

Verification
REQ-024 The bench SHALL cover: add A=5, B=7, mode 0, ALU ready in cycle 3 -> alu_valid in cycle 2 only, res_valid in cycle 4, res_data = 12, res_err = 0.
REQ-025 The bench SHALL cover: 5 back-to-back commands, res_ready held low -> cmd_ready drops after the 4th accepted command plus one pop, and results exit in order.
REQ-026 The bench SHALL cover: mode 4'b1101 -> no alu_valid pulse, res_valid with res_data = 0 and res_err = 1.
REQ-027 The bench SHALL cover: ALU never answers, macro defined -> res_err = 1 after 64 WAIT cycles; macro undefined -> FSM stays in WAIT.
REQ-028 The bench SHALL cover: rst_n pulsed low while in WAIT with 2 entries queued -> all outputs 0, FIFO empty, and a subsequent alu_ready pulse produces no res_valid.
REQ-029 The bench SHALL cover: mul A=3, B=4, mode 9, ready after 33 cycles -> res_data = 12, and alu_ready in RESP is ignored.
